// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared constants and state type for the fetch sequencer.
// Revision    : 1.0
// ============================================================================
package fetch_sequencer_pkg;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [3:0]  DEF_HALT_OP   = 4'hF;

  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GEQ    = 3'b100;
  localparam logic [2:0] COND_LEQ    = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_branch_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_eval
// Description : Combinational condition check and branch target computation.
// Revision    : 1.0
// ============================================================================
module branch_eval
  import fetch_sequencer_pkg::*;
(
  input  logic [2:0]  i_cond,
  input  logic [2:0]  i_flags,
  input  logic [15:0] i_pc,
  input  logic [8:0]  i_imm,
  output logic        o_taken,
  output logic [15:0] o_target
);

  logic w_n;
  logic w_v;
  logic w_z;

  assign {w_n, w_v, w_z} = i_flags;

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_NEQ:    o_taken = ~w_z;
      COND_EQ:     o_taken = w_z;
      COND_GT:     o_taken = ~w_z & ~w_n;
      COND_LT:     o_taken = w_n;
      COND_GEQ:    o_taken = w_z | ~w_n;
      COND_LEQ:    o_taken = w_z | w_n;
      COND_OVFL:   o_taken = w_v;
      COND_UNCOND: o_taken = 1'b1;
      default:     o_taken = 1'b1;
    endcase
  end

  // Word offset relative to the instruction after the branch; wraps mod 2^16.
  assign o_target = i_pc + 16'd2 + {{6{i_imm[8]}}, i_imm, 1'b0};

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : PC owner and instruction fetch sequencer with branch redirect,
//               wrong-path squash and HLT freeze. Optional perf counters are
//               enabled by defining FETCH_PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [3:0]  HALT_OP   = DEF_HALT_OP
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int          CNT_W     = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [2:0]  br_flags,
  input  logic [15:0] br_pc,
  output logic        br_taken,
  output logic        flush,
  output logic        halted,
  output logic [15:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_stall
`endif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic        r_valid;
  logic [15:0] r_instr;
  logic [15:0] r_ipc;
  logic        r_flush;
  logic        r_squash;
  logic        r_out;

  logic        w_cond_met;
  logic [15:0] w_target;
  logic        w_req;
  logic        w_fill;
  logic        w_is_halt;

  branch_eval u_branch_eval (
    .i_cond   (br_cond),
    .i_flags  (br_flags),
    .i_pc     (br_pc),
    .i_imm    (br_imm),
    .o_taken  (w_cond_met),
    .o_target (w_target)
  );

  assign br_taken  = br_valid & w_cond_met;

  // A new request is only started when the buffer is free or draining, so an
  // in-flight response always finds the buffer empty; an issued one is held.
  assign w_req     = (r_state == REQ) & ~r_squash & (r_out | ~r_valid | if_ready);
  assign w_fill    = w_req & imem_rdy & ~br_taken;
  assign w_is_halt = (imem_data[15:12] == HALT_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ: begin
        if (w_fill && w_is_halt) begin
          w_state_nxt = HALTED;
        end else if (!r_squash && !w_req) begin
          w_state_nxt = STALL;
        end
      end
      STALL: begin
        if (!r_valid || if_ready) begin
          w_state_nxt = REQ;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
    if (br_taken) begin
      w_state_nxt = REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_VEC;
      r_valid  <= 1'b0;
      r_instr  <= 16'h0000;
      r_ipc    <= 16'h0000;
      r_flush  <= 1'b0;
      r_squash <= 1'b0;
      r_out    <= 1'b0;
    end else begin
      r_flush <= br_taken;
      r_out   <= ~br_taken & w_req & ~imem_rdy;
      if (br_taken) begin
        r_pc     <= w_target;
        r_valid  <= 1'b0;
        // Any response still owed by memory belongs to the wrong path.
        r_squash <= (w_req | r_squash) & ~imem_rdy;
      end else begin
        if (imem_rdy) begin
          r_squash <= 1'b0;
        end
        if (w_fill) begin
          r_valid <= 1'b1;
          r_instr <= imem_data;
          r_ipc   <= r_pc;
          if (!w_is_halt) begin
            r_pc <= r_pc + 16'd2;
          end
        end else if (if_ready) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_ipc;
  assign flush     = r_flush;
  assign halted    = (r_state == HALTED);
  assign pc        = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_taken;
  logic [CNT_W-1:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_taken <= '0;
      r_perf_stall <= '0;
    end else begin
      if (br_taken && !(&r_perf_taken)) begin
        r_perf_taken <= r_perf_taken + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_valid && !if_ready && !(&r_perf_stall)) begin
        r_perf_stall <= r_perf_stall + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_taken = r_perf_taken;
  assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer with a variable-latency
//               memory model and a behavioural fetch/branch reference.
// Revision    : 1.0
// ============================================================================
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'd0;
  logic [8:0]  br_imm = 9'd0;
  logic [2:0]  br_flags = 3'd0;
  logic [15:0] br_pc = 16'd0;
  logic        br_taken;
  logic        flush;
  logic        halted;
  logic [15:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_taken;
  logic [15:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: latency chosen per request, one rdy pulse per request.
  logic        m_busy;
  logic [1:0]  m_cnt;
  logic [15:0] m_addr;
  logic [1:0]  m_rv = 2'd0;
  logic [1:0]  m_fixed = 2'd0;
  logic        m_rand = 1'b0;
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;
  logic [1:0]  w_lat;

  function automatic logic [15:0] word_at(input logic [15:0] a, input logic en, input logic [15:0] ha);
    return (en && a == ha) ? 16'hF000 : {4'h1, a[12:1]};
  endfunction

  function automatic logic cond_met(input int c, input logic [2:0] f);
    logic n, v, z;
    {n, v, z} = f;
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] exp_target(input logic [15:0] bpc, input logic [8:0] imm);
    int off;
    off = int'(imm);
    if (imm[8]) off -= 512;
    return 16'(int'(bpc) + 2 + 2 * off);
  endfunction

  assign w_lat     = m_rand ? m_rv : m_fixed;
  assign imem_rdy  = m_busy ? (m_cnt == 2'd0) : (imem_req && w_lat == 2'd0);
  assign imem_data = word_at(m_busy ? m_addr : imem_addr, halt_en, halt_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 2'd0;
      m_addr <= 16'h0000;
    end else if (m_busy) begin
      if (m_cnt == 2'd0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 2'd1;
    end else if (imem_req) begin
      m_rv <= 2'($urandom_range(0, 3));
      if (w_lat != 2'd0) begin
        m_busy <= 1'b1;
        m_cnt  <= w_lat - 2'd1;
        m_addr <= imem_addr;
      end
    end
  end

  fetch_sequencer #(.RESET_VEC(RV), .HALT_OP(4'hF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdy  (imem_rdy),
    .imem_data (imem_data),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .br_imm    (br_imm),
    .br_flags  (br_flags),
    .br_pc     (br_pc),
    .br_taken  (br_taken),
    .flush     (flush),
    .halted    (halted),
    .pc        (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_taken(perf_taken),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    br_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || flush !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got req=%b valid=%b flush=%b halted=%b expected all 0", imem_req, if_valid, flush, halted);
    end
    n_checks++;
    if (pc !== RV || if_instr !== 16'h0000 || if_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data got pc=%h instr=%h ifpc=%h expected %h/0000/0000", pc, if_instr, if_pc, RV);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_straight();
    m_rand = 1'b0; m_fixed = 2'd0; halt_en = 1'b0; if_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(2 * (k - 1))) begin
        n_fail++;
        $display("FAIL straight_req k=%0d got req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, 16'(2 * (k - 1)));
      end
      if (k >= 2) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'(2 * (k - 2)) || if_instr !== word_at(16'(2 * (k - 2)), 1'b0, 16'h0)) begin
          n_fail++;
          $display("FAIL straight_out k=%0d got v=%b pc=%h instr=%h expected pc=%h", k, if_valid, if_pc, if_instr, 16'(2 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    m_rand = 1'b0; m_fixed = 2'd0; halt_en = 1'b0; if_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if_ready = 1'b0;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0004 || if_instr !== word_at(16'h0004, 1'b0, 16'h0)) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d got req=%b v=%b pc=%h instr=%h expected 0/1/0004/%h", k, imem_req, if_valid, if_pc, if_instr, word_at(16'h0004, 1'b0, 16'h0));
      end
    end
    @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_stall !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_perf_stall got %0d expected 3", perf_stall);
    end
`endif
    if_ready = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); #1;
      if (if_valid) begin
        got = 1'b1;
        n_checks++;
        if (if_pc !== 16'h0006 || if_instr !== word_at(16'h0006, 1'b0, 16'h0)) begin
          n_fail++;
          $display("FAIL bp_resume got pc=%h instr=%h expected 0006", if_pc, if_instr);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL bp_resume_timeout got no entry expected pc=0006");
    end
  endtask

  task automatic test_branch_squash();
    bit found, saw_sq, bad, got;
    m_rand = 1'b0; m_fixed = 2'd2; halt_en = 1'b0; if_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk); #1;
      if (m_busy && imem_req && !imem_rdy) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL sq_inflight_timeout got no outstanding request expected one");
    end
    br_pc = 16'h0010; br_imm = 9'h1FE; br_cond = 3'b111; br_flags = 3'b000; br_valid = 1'b1;
    #1;
    n_checks++;
    if (br_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL sq_br_taken got %b expected 1", br_taken);
    end
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    n_checks++;
    if (flush !== 1'b1 || pc !== 16'h000E || if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sq_redirect got flush=%b pc=%h v=%b req=%b expected 1/000E/0/0", flush, pc, if_valid, imem_req);
    end
    saw_sq = imem_rdy && !imem_req;
    bad = 1'b0; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk); #1;
      if (if_valid) bad = 1'b1;
      if (imem_rdy && !imem_req) saw_sq = 1'b1;
      if (imem_req) found = 1'b1;
    end
    n_checks++;
    if (!found || imem_addr !== 16'h000E || !saw_sq || bad || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL sq_target_req got found=%b addr=%h after_sq=%b stray=%b flush=%b expected 1/000E/1/0/0", found, imem_addr, saw_sq, bad, flush);
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); #1;
      if (if_valid) got = 1'b1;
    end
    n_checks++;
    if (!got || if_pc !== 16'h000E || if_instr !== word_at(16'h000E, 1'b0, 16'h0)) begin
      n_fail++;
      $display("FAIL sq_target_out got v=%b pc=%h instr=%h expected 1/000E/%h", got, if_pc, if_instr, word_at(16'h000E, 1'b0, 16'h0));
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (perf_taken !== 16'd1) begin
      n_fail++;
      $display("FAIL sq_perf_taken got %0d expected 1", perf_taken);
    end
`endif
    // Response and taken branch in the same cycle.
    m_fixed = 2'd0;
    do_reset();
    @(negedge clk);
    br_pc = 16'h0100; br_imm = 9'h010; br_cond = 3'b111; br_valid = 1'b1;
    #1;
    n_checks++;
    if (br_taken !== 1'b1 || imem_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_setup got taken=%b rdy=%b expected 1/1", br_taken, imem_rdy);
    end
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || pc !== 16'h0122 || imem_req !== 1'b1 || imem_addr !== 16'h0122) begin
      n_fail++;
      $display("FAIL same_cycle got v=%b pc=%h req=%b addr=%h expected 0/0122/1/0122", if_valid, pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_conditions();
    logic e;
    m_rand = 1'b1; halt_en = 1'b0; if_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        @(negedge clk);
        br_pc = 16'($urandom); br_imm = 9'($urandom);
        br_cond = 3'(c); br_flags = 3'(f); br_valid = 1'b1;
        #1;
        e = cond_met(c, 3'(f));
        n_checks++;
        if (br_taken !== e) begin
          n_fail++;
          $display("FAIL cond c=%0d f=%03b got taken=%b expected %b", c, 3'(f), br_taken, e);
        end
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        n_checks++;
        if (flush !== e || (e && pc !== exp_target(br_pc, br_imm))) begin
          n_fail++;
          $display("FAIL cond_redirect c=%0d f=%03b got flush=%b pc=%h expected flush=%b target=%h", c, 3'(f), flush, pc, e, exp_target(br_pc, br_imm));
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] e_pc;
    int hs;
    m_rand = 1'b1; halt_en = 1'b0; if_ready = 1'b1;
    do_reset();
    e_pc = RV; hs = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (if_valid) begin
        n_checks++;
        if (if_pc !== e_pc || if_instr !== word_at(e_pc, 1'b0, 16'h0)) begin
          n_fail++;
          $display("FAIL stream k=%0d got pc=%h instr=%h expected %h/%h", k, if_pc, if_instr, e_pc, word_at(e_pc, 1'b0, 16'h0));
        end
        if (if_ready) begin
          e_pc = e_pc + 16'd2;
          hs++;
        end
      end
      if (m_busy && imem_req) begin
        n_checks++;
        if (imem_addr !== m_addr) begin
          n_fail++;
          $display("FAIL addr_stable k=%0d got %h expected %h", k, imem_addr, m_addr);
        end
      end
    end
    n_checks++;
    if (hs < 40) begin
      n_fail++;
      $display("FAIL stream_progress got %0d deliveries expected >= 40", hs);
    end
  endtask

  task automatic test_halt();
    logic [15:0] e_pc;
    int got;
    bit ok;
    m_rand = 1'b0; m_fixed = 2'd0; halt_en = 1'b1; halt_addr = 16'h0006; if_ready = 1'b1;
    do_reset();
    e_pc = 16'h0000; got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      @(negedge clk); #1;
      if (if_valid) begin
        n_checks++;
        if (if_pc !== e_pc || if_instr !== word_at(e_pc, 1'b1, 16'h0006)) begin
          n_fail++;
          $display("FAIL halt_stream got pc=%h instr=%h expected %h/%h", if_pc, if_instr, e_pc, word_at(e_pc, 1'b1, 16'h0006));
        end
        e_pc = e_pc + 16'd2;
        got++;
      end
    end
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL halt_count got %0d expected 4", got);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0006 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_frozen k=%0d got halted=%b req=%b pc=%h v=%b expected 1/0/0006/0", k, halted, imem_req, pc, if_valid);
      end
    end
    @(negedge clk);
    br_pc = 16'h001E; br_imm = 9'h000; br_cond = 3'b111; br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b0 || pc !== 16'h0020) begin
      n_fail++;
      $display("FAIL halt_exit got halted=%b pc=%h expected 0/0020", halted, pc);
    end
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk); #1;
      if (if_valid) ok = 1'b1;
    end
    n_checks++;
    if (!ok || if_pc !== 16'h0020) begin
      n_fail++;
      $display("FAIL halt_resume got v=%b pc=%h expected 1/0020", ok, if_pc);
    end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap_reset();
    logic [15:0] e_pc;
    int got;
    bit ok;
    m_rand = 1'b0; m_fixed = 2'd0; halt_en = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    br_pc = 16'hFFFA; br_imm = 9'h001; br_cond = 3'b111; br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    e_pc = 16'hFFFE; got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk); #1;
      if (if_valid) begin
        n_checks++;
        if (if_pc !== e_pc || if_instr !== word_at(e_pc, 1'b0, 16'h0)) begin
          n_fail++;
          $display("FAIL wrap got pc=%h instr=%h expected %h", if_pc, if_instr, e_pc);
        end
        e_pc = e_pc + 16'd2;
        got++;
      end
    end
    n_checks++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL wrap_count got %0d expected 3", got);
    end
    m_fixed = 2'd3;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk); #1;
      if (m_busy && imem_req) ok = 1'b1;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || imem_req !== 1'b0 || pc !== RV || if_valid !== 1'b0 || if_pc !== 16'h0000 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got wait=%b req=%b pc=%h v=%b ifpc=%h flush=%b expected 1/0/%h/0/0000/0", ok, imem_req, pc, if_valid, if_pc, flush, RV);
    end
    m_fixed = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk); #1;
      if (if_valid) ok = 1'b1;
    end
    n_checks++;
    if (!ok || if_pc !== RV) begin
      n_fail++;
      $display("FAIL reset_restart got v=%b pc=%h expected 1/%h", ok, if_pc, RV);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_branch_squash();
    test_conditions();
    test_random_stream();
    test_halt();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the architectural PC and sequences instruction fetch from a variable-latency instruction memory. It resolves branches sent back from decode with the processor's condition/flag rules and redirects the PC. It flushes wrong-path fetches and freezes on HLT. It sits between the instruction memory and the IF/ID pipeline register.

Parameters:
RESET_VEC, 16'h0000, PC value loaded on reset
HALT_OP, 4'hF, opcode (instr[15:12]) that halts fetch
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_rdy
imem_addr  out  16  fetch address (= pc while imem_req)
imem_rdy  in  1  memory response valid, one cycle per request
imem_data  in  16  fetched instruction word
if_valid  out  1  instruction buffer holds a valid entry
if_ready  in  1  IF/ID accepts the entry this cycle
if_instr  out  16  buffered instruction
if_pc  out  16  address of if_instr
br_valid  in  1  decode presents a branch for resolution (1-cycle pulse)
br_cond  in  3  condition code: 000 NEQ, 001 EQ, 010 GT, 011 LT, 100 GEQ, 101 LEQ, 110 OVFL, 111 UNCOND
br_imm  in  9  signed word offset
br_flags  in  3  flags {N,V,Z}
br_pc  in  16  address of the branch instruction
br_taken  out  1  combinational: br_valid and the condition is met
flush  out  1  registered, 1-cycle pulse after a taken branch
halted  out  1  high in HALTED state
pc  out  16  current fetch PC

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC, state=IDLE.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, flush=0, halted=0, squash=0.
- States:
  - IDLE: goes to REQ on the next edge.
  - REQ: assert imem_req with imem_addr=pc. On imem_rdy, capture the word. Stay in REQ if another fetch is allowed.
  - STALL: the buffer is full and if_ready=0. imem_req=0. Return to REQ once the buffer drains.
  - HALTED: imem_req=0, halted=1.
- Condition evaluation:
  - NEQ: ~Z.
  - EQ: Z.
  - GT: ~Z&~N.
  - LT: N.
  - GEQ: Z|~N.
  - LEQ: Z|N.
  - OVFL: V.
  - UNCOND: 1.
- Branch target: br_pc + 2 + (sext(br_imm) << 1), computed mod 2^16.
- Sequential PC: pc+2 mod 2^16, so 16'hFFFE wraps to 16'h0000.
- Buffer: a single entry.
  - Fill on imem_rdy when the buffer is empty, or when it drains in the same cycle.
  - if_valid drops on if_ready unless a refill arrives in the same cycle.
  - pc advances by 2 on each accepted fill.
  - Fetch-to-if_valid latency = memory latency + 1 cycle.
- Taken branch (br_taken=1) has the highest priority:
  - Next edge: pc=target, if_valid=0, flush=1 for one cycle.
  - State goes to REQ from any state, including HALTED.
  - If a request is outstanding (imem_req=1, no imem_rdy yet), set squash. The next imem_rdy is then discarded and squash clears.
  - The target request is issued only after the squashed response returns.
  - If imem_rdy and br_taken occur in the same cycle, the response is discarded.
- Not-taken branch: no effect.
- HLT:
  - A captured word with imem_data[15:12]==HALT_OP is delivered normally.
  - The state goes to HALTED and pc stays at the HLT address (it does not advance).
  - HALTED is left only by a taken branch or by reset.
- Priority: taken branch > halt > sequential fetch.
- imem_addr is stable while imem_req=1 and imem_rdy=0.

Optional Feature:
FETCH_PERF_CNT_EN
- When defined, adds outputs perf_taken[CNT_W-1:0] and perf_stall[CNT_W-1:0]. Both reset to 0 and saturate at all-ones.
  - perf_taken counts taken branches.
  - perf_stall counts cycles with if_valid=1 and if_ready=0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Condition-code constants (COND_NEQ..COND_UNCOND).
  - HALT_OP and RESET_VEC defaults.
  - The state enum (IDLE, REQ, STALL, HALTED).
- One combinational sub-module, branch_eval, maps (cond, flags, pc, imm) to (taken, target).
- The FSM, buffer and squash logic stay in fetch_sequencer.

Test Plan:
- Straight-line fetch, 0-wait memory, if_ready=1: reset release -> addresses 0000, 0002, 0004 on consecutive requests, if_pc matching, no bubbles after the first.
- Backpressure: if_ready=0 for 3 cycles with buffer full -> imem_req=0, if_instr stable, perf_stall=3. On release, fetch resumes at the next PC.
- Taken branch with a 2-wait response in flight: br_pc=0010, imm=9'h1FE (-2), cond=111 -> target 000E, flush pulse. The in-flight word is never seen on if_valid, and the next request has imem_addr=000E.
- Condition coverage: each of the 8 codes against all 8 flag combinations -> br_taken matches the table. GEQ with N=1,Z=1 is taken; GT with N=0,Z=1 is not.
- Halt: word F000 fetched at 0006 -> delivered with if_pc=0006, then halted=1, pc=0006, imem_req=0 indefinitely. A later taken branch to 0020 resumes fetch there.
- Wrap and reset: fetch at FFFE -> next address 0000. Asserting rst_n=0 mid-wait -> outputs reset immediately (asynchronously), and fetch restarts at RESET_VEC.
